// File: rtl/uart_bridge_pkg.sv
// Shared constants, state types and framing helper for the UART-to-cbus host bridge.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    typedef enum logic [2:0] {
        P_IDLE,
        P_ADDR,
        P_DATA,
        P_EXEC,
        P_RESP
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // 8N1 character as shifted out LSB first: start(0), data, stop(1)
    function automatic logic [9:0] uart_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit glitch rejection, mid-bit sampling.
module uart_rx_byte
    import uart_bridge_pkg::*;
#(
    parameter int unsigned CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ser_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned      TW        = $clog2(CLK_DIV);
    localparam logic [TW-1:0]    HALF_LAST = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0]    BIT_LAST  = TW'(CLK_DIV - 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    rx_state_t     r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;
    logic          w_rx;
    logic          w_stop_sample;

    assign w_rx          = r_sync[1];
    assign w_stop_sample = (r_state == RX_STOP) && (r_timer == BIT_LAST);
    assign byte_valid    = w_stop_sample && w_rx;
    assign frame_err     = w_stop_sample && !w_rx;
    assign byte_data     = r_shift;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_timer <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
        end else begin
            r_sync <= {r_sync[0], ser_rx};
            r_prev <= w_rx;
            case (r_state)
                RX_IDLE: begin
                    r_timer <= '0;
                    // Only a falling edge starts a byte, so a line held low after a framing error is ignored
                    if (r_prev && !w_rx) r_state <= RX_START;
                end
                RX_START: begin
                    if (r_timer == HALF_LAST) begin
                        r_timer <= '0;
                        r_bitn  <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer <= '0;
                        r_state <= RX_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_to_cbus_bridge.sv
// Host bridge: parses 'W'/'R' command frames from the UART into single cbus
// transactions and returns 'K', read data or 'E' on the transmit line.
module uart_to_cbus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 104,
    parameter int unsigned GAP_TIMEOUT = 1000000,
    parameter int unsigned BUS_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic        cbus_valid,
    input  logic        cbus_ready,
    output logic [3:0]  cbus_wstrb,
    output logic [31:0] cbus_addr,
    output logic [31:0] cbus_wdata,
    input  logic [31:0] cbus_rdata
);

    localparam int unsigned    BTW      = $clog2(CLK_DIV);
    localparam int unsigned    GTW      = $clog2(GAP_TIMEOUT + 1);
    localparam int unsigned    STW      = $clog2(BUS_TIMEOUT + 1);
    localparam logic [BTW-1:0] BIT_LAST = BTW'(CLK_DIV - 1);
    localparam logic [GTW-1:0] GAP_LAST = GTW'(GAP_TIMEOUT - 1);
    localparam logic [STW-1:0] BUS_LAST = STW'(BUS_TIMEOUT - 1);

    logic          w_byte_valid;
    logic          w_frame_err;
    logic [7:0]    w_byte_data;

    parser_state_t  r_state;
    logic           r_is_write;
    logic [1:0]     r_cnt;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic           r_valid;
    logic [3:0]     r_wstrb;
    logic [GTW-1:0] r_gap;
    logic [STW-1:0] r_bus;
    logic [31:0]    r_rsp;
    logic [1:0]     r_rsp_left;
    logic [9:0]     r_tx_shift;
    logic [3:0]     r_tx_bitn;
    logic [BTW-1:0] r_tx_timer;

    uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .ser_rx     (ser_rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err)
    );

    assign ser_tx     = r_tx_shift[0];
    assign cbus_valid = r_valid;
    assign cbus_wstrb = r_wstrb;
    assign cbus_addr  = r_addr;
    assign cbus_wdata = r_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= P_IDLE;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_valid    <= 1'b0;
            r_wstrb    <= '0;
            r_gap      <= '0;
            r_bus      <= '0;
            r_rsp      <= '0;
            r_rsp_left <= '0;
            r_tx_shift <= '1;
            r_tx_bitn  <= '0;
            r_tx_timer <= '0;
        end else begin
            case (r_state)
                P_IDLE: begin
                    r_gap <= '0;
                    r_cnt <= '0;
                    if (w_byte_valid && (w_byte_data == CMD_WRITE || w_byte_data == CMD_READ)) begin
                        r_is_write <= (w_byte_data == CMD_WRITE);
                        r_state    <= P_ADDR;
                    end
                end
                P_ADDR, P_DATA: begin
                    if (w_frame_err) begin
                        r_state <= P_IDLE;
                    end else if (w_byte_valid) begin
                        r_gap <= '0;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_state == P_ADDR) r_addr[{r_cnt, 3'b000} +: 8]  <= w_byte_data;
                        else                   r_wdata[{r_cnt, 3'b000} +: 8] <= w_byte_data;
                        if (r_cnt == 2'd3) begin
                            if (r_state == P_ADDR && r_is_write) begin
                                r_state <= P_DATA;
                            end else begin
                                r_state <= P_EXEC;
                                r_valid <= 1'b1;
                                r_wstrb <= r_is_write ? 4'hF : 4'h0;
                                r_bus   <= '0;
                            end
                        end
                    end else if (r_gap == GAP_LAST) begin
                        r_state <= P_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                P_EXEC: begin
                    // First response byte is loaded here so its start bit follows ready/timeout directly
                    if (cbus_ready) begin
                        r_valid    <= 1'b0;
                        r_wstrb    <= '0;
                        r_state    <= P_RESP;
                        r_tx_bitn  <= '0;
                        r_tx_timer <= '0;
                        if (r_is_write) begin
                            r_tx_shift <= uart_frame(RSP_ACK);
                            r_rsp_left <= 2'd0;
                        end else begin
                            r_tx_shift <= uart_frame(cbus_rdata[7:0]);
                            r_rsp      <= {8'h00, cbus_rdata[31:8]};
                            r_rsp_left <= 2'd3;
                        end
                    end else if (r_bus == BUS_LAST) begin
                        r_valid    <= 1'b0;
                        r_wstrb    <= '0;
                        r_state    <= P_RESP;
                        r_tx_bitn  <= '0;
                        r_tx_timer <= '0;
                        r_tx_shift <= uart_frame(RSP_ERR);
                        r_rsp_left <= 2'd0;
                    end else begin
                        r_bus <= r_bus + 1'b1;
                    end
                end
                P_RESP: begin
                    if (r_tx_timer != BIT_LAST) begin
                        r_tx_timer <= r_tx_timer + 1'b1;
                    end else begin
                        r_tx_timer <= '0;
                        if (r_tx_bitn != 4'd9) begin
                            r_tx_bitn  <= r_tx_bitn + 4'd1;
                            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                        end else if (r_rsp_left != 2'd0) begin
                            r_tx_bitn  <= '0;
                            r_tx_shift <= uart_frame(r_rsp[7:0]);
                            r_rsp      <= {8'h00, r_rsp[31:8]};
                            r_rsp_left <= r_rsp_left - 2'd1;
                        end else begin
                            r_tx_bitn  <= '0;
                            r_tx_shift <= '1;
                            r_state    <= P_IDLE;
                        end
                    end
                end
                default: r_state <= P_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_to_cbus_bridge.sv
// Self-checking bench: randomized UART frames against a frame-level model of the bridge.
`timescale 1ns/1ps
module tb_uart_to_cbus_bridge;

    localparam int unsigned CLK_DIV     = 16;
    localparam int unsigned BUS_TIMEOUT = 32;
    localparam int unsigned GAP_TIMEOUT = 2000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ser_rx;
    logic        ser_tx;
    logic        cbus_valid;
    logic        cbus_ready;
    logic [3:0]  cbus_wstrb;
    logic [31:0] cbus_addr;
    logic [31:0] cbus_wdata;
    logic [31:0] cbus_rdata;

    always #5 clk = ~clk;

    uart_to_cbus_bridge #(
        .CLK_DIV     (CLK_DIV),
        .GAP_TIMEOUT (GAP_TIMEOUT),
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ser_rx     (ser_rx),
        .ser_tx     (ser_tx),
        .cbus_valid (cbus_valid),
        .cbus_ready (cbus_ready),
        .cbus_wstrb (cbus_wstrb),
        .cbus_addr  (cbus_addr),
        .cbus_wdata (cbus_wdata),
        .cbus_rdata (cbus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wr;
        int          vlen;
    } txn_t;

    int          total = 0;
    int          bad   = 0;
    txn_t        exp_txn[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  last_rsp[$];
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    int          n_txn = 0;
    int          slv_lat = 1;
    logic [31:0] slv_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level model: slave latency 1..BUS_TIMEOUT succeeds, anything else is a bus timeout.
    task automatic model_frame(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input int lat, input logic [31:0] rd);
        txn_t t;
        bit   ok;
        ok      = (lat >= 1) && (lat <= int'(BUS_TIMEOUT));
        t.addr  = addr;
        t.wdata = data;
        t.wr    = wr;
        t.vlen  = ok ? lat : int'(BUS_TIMEOUT);
        exp_txn.push_back(t);
        if (!ok)     exp_rsp.push_back(8'h45);
        else if (wr) exp_rsp.push_back(8'h4B);
        else for (int i = 0; i < 4; i++) exp_rsp.push_back(rd[8*i +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        ser_rx = 1'b0;
        wait_cycles(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            wait_cycles(CLK_DIV);
        end
        ser_rx = stop_ok;
        wait_cycles(CLK_DIV);
        ser_rx = 1'b1;
    endtask

    task automatic send_frame(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        send_byte(wr ? 8'h57 : 8'h52, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_cycles($urandom_range(0, 12));
            send_byte(addr[8*i +: 8], 1'b1);
        end
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                wait_cycles($urandom_range(0, 12));
                send_byte(data[8*i +: 8], 1'b1);
            end
        end
    endtask

    task automatic collect(input string tag);
        int         n;
        int         t;
        logic [7:0] got;
        n = exp_rsp.size();
        t = 0;
        while (rx_q.size() < n && t < 3000) begin
            wait_cycles(1);
            t++;
        end
        wait_cycles(200);
        check({tag, "_rsp_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : ~exp_rsp[i];
            check({tag, "_rsp_byte"}, got, exp_rsp[i]);
        end
        check({tag, "_txn_done"}, exp_txn.size(), 0);
        last_rsp = rx_q;
        rx_q.delete();
        exp_rsp.delete();
        exp_txn.delete();
    endtask

    task automatic run_frame(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             input int lat, input logic [31:0] rd, input string tag);
        slv_lat   = lat;
        slv_rdata = rd;
        model_frame(wr, addr, data, lat, rd);
        send_frame(wr, addr, data);
        collect(tag);
    endtask

    task automatic lit_rsp(input string name, input int i, input logic [7:0] expv);
        logic [7:0] got;
        got = (i < last_rsp.size()) ? last_rsp[i] : ~expv;
        check(name, got, expv);
    endtask

    // cbus slave: asserts ready in the lat-th cycle of valid (lat=0: never); late pulses still fire.
    initial begin : slave
        bit busy;
        int cnt;
        int lat;
        busy = 0;
        cnt  = 0;
        lat  = 0;
        cbus_ready = 1'b0;
        cbus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cbus_ready = 1'b0;
            cbus_rdata = $urandom;
            if (!resetn) begin
                busy = 0;
            end else if (!busy) begin
                if (cbus_valid) begin
                    busy = 1;
                    cnt  = 1;
                    lat  = slv_lat;
                    if (lat == 1) begin
                        cbus_ready = 1'b1;
                        cbus_rdata = slv_rdata;
                        busy = 0;
                    end
                end
            end else begin
                cnt++;
                if (lat != 0 && cnt == lat) begin
                    cbus_ready = 1'b1;
                    cbus_rdata = slv_rdata;
                    busy = 0;
                end else if (!cbus_valid && (lat == 0 || cnt > lat)) begin
                    busy = 0;
                end
            end
        end
    end

    // UART receiver for ser_tx; bytes interrupted by reset are discarded.
    initial begin : tx_mon
        logic [7:0] b;
        bit         aborted;
        b = '0;
        forever begin
            @(negedge clk);
            if (resetn && ser_tx === 1'b0) begin
                aborted = 0;
                repeat (CLK_DIV / 2 - 1) begin
                    @(negedge clk);
                    if (!resetn) aborted = 1;
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) begin
                        @(negedge clk);
                        if (!resetn) aborted = 1;
                    end
                    b[i] = ser_tx;
                end
                repeat (CLK_DIV) begin
                    @(negedge clk);
                    if (!resetn) aborted = 1;
                end
                if (!aborted) begin
                    check("tx_stop_bit", ser_tx, 1);
                    rx_q.push_back(b);
                end
            end
        end
    end

    // Per-cycle bus checker against the model's expected transactions.
    initial begin : cmp
        bit          pv;
        bit          have;
        int          run;
        txn_t        cur;
        logic [31:0] ha;
        logic [31:0] hd;
        logic [3:0]  hs;
        pv = 0; have = 0; run = 0;
        ha = '0; hd = '0; hs = '0;
        cur.addr = '0; cur.wdata = '0; cur.wr = 0; cur.vlen = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                run  = 0;
                have = 0;
            end else begin
                if (cbus_valid && !pv) begin
                    n_txn++;
                    last_addr  = cbus_addr;
                    last_wdata = cbus_wdata;
                    check("txn_expected", 32'(exp_txn.size() > 0), 1);
                    if (exp_txn.size() > 0) begin
                        cur  = exp_txn.pop_front();
                        have = 1;
                        check("txn_addr", cbus_addr, cur.addr);
                        check("txn_wstrb", cbus_wstrb, cur.wr ? 4'hF : 4'h0);
                        if (cur.wr) check("txn_wdata", cbus_wdata, cur.wdata);
                    end else begin
                        have = 0;
                    end
                    ha  = cbus_addr;
                    hd  = cbus_wdata;
                    hs  = cbus_wstrb;
                    run = 1;
                end else if (cbus_valid) begin
                    run++;
                    check("stable_addr", cbus_addr, ha);
                    check("stable_wdata", cbus_wdata, hd);
                    check("stable_wstrb", cbus_wstrb, hs);
                end else if (pv) begin
                    if (have) check("valid_len", run, cur.vlen);
                    check("tx_start_after_bus", ser_tx, 0);
                end
                if (!cbus_valid) check("wstrb_idle", cbus_wstrb, 0);
            end
            pv = cbus_valid;
        end
    end

    initial begin : watchdog
        #3ms;
        bad++;
        $display("FAIL watchdog: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : main
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic [7:0]  stray;
        bit          wr;
        int          lat;
        int          sel;
        int          n0;
        int          t;

        ser_rx = 1'b1;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        wait_cycles(5);
        check("rst_ser_tx", ser_tx, 1);
        check("rst_valid", cbus_valid, 0);
        check("rst_wstrb", cbus_wstrb, 0);
        check("rst_addr", cbus_addr, 0);
        check("rst_wdata", cbus_wdata, 0);
        resetn = 1'b1;
        wait_cycles(20);

        run_frame(1, 32'h40000010, 32'hDEADBEEF, 3, 32'h0, "wr");
        check("wr_addr_lit", last_addr, 32'h40000010);
        check("wr_wdata_lit", last_wdata, 32'hDEADBEEF);
        check("wr_rsp_len_lit", last_rsp.size(), 1);
        lit_rsp("wr_rsp_lit", 0, 8'h4B);

        run_frame(0, 32'h40000004, 32'h0, 5, 32'h12345678, "rd");
        check("rd_addr_lit", last_addr, 32'h40000004);
        lit_rsp("rd_rsp0_lit", 0, 8'h78);
        lit_rsp("rd_rsp1_lit", 1, 8'h56);
        lit_rsp("rd_rsp2_lit", 2, 8'h34);
        lit_rsp("rd_rsp3_lit", 3, 8'h12);

        run_frame(0, 32'h00000100, 32'h0, 0, 32'hCAFEF00D, "tmo");
        check("tmo_rsp_len_lit", last_rsp.size(), 1);
        lit_rsp("tmo_rsp_lit", 0, 8'h45);

        n0 = n_txn;
        send_byte(8'hAA, 1'b1);
        wait_cycles(20);
        send_byte(8'h57, 1'b0);
        wait_cycles(300);
        check("stray_no_tx", rx_q.size(), 0);
        check("stray_no_txn", n_txn, n0);
        run_frame(1, 32'h00000A0C, 32'h0BADF00D, 1, 32'h0, "post_stray");

        n0 = n_txn;
        send_byte(8'h57, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_cycles(GAP_TIMEOUT + 100);
        check("gap_no_tx", rx_q.size(), 0);
        check("gap_no_txn", n_txn, n0);
        run_frame(0, 32'h20000008, 32'h0, BUS_TIMEOUT, 32'hA5A50F0F, "post_gap");
        check("post_gap_addr_lit", last_addr, 32'h20000008);
        lit_rsp("ready_at_expiry_lit", 0, 8'h0F);

        run_frame(1, 32'h00000044, 32'h87654321, BUS_TIMEOUT + 1, 32'h0, "lat33");
        lit_rsp("lat33_rsp_lit", 0, 8'h45);

        for (int k = 0; k < 14; k++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom;
            d   = $urandom;
            rd  = $urandom;
            sel = $urandom_range(0, 9);
            lat = (sel < 7) ? $urandom_range(1, BUS_TIMEOUT) :
                  (sel < 9) ? $urandom_range(BUS_TIMEOUT + 1, BUS_TIMEOUT + 13) : 0;
            if ($urandom_range(0, 3) == 0) begin
                stray = 8'($urandom);
                if (stray == 8'h57 || stray == 8'h52) stray = 8'hA5;
                send_byte(stray, 1'b1);
                wait_cycles($urandom_range(0, 12));
            end
            run_frame(wr, a, d, lat, rd, "rnd");
        end

        slv_lat   = 2;
        slv_rdata = 32'h600DCAFE;
        model_frame(0, 32'h00000030, 32'h0, 2, 32'h600DCAFE);
        send_frame(0, 32'h00000030, 32'h0);
        t = 0;
        while (ser_tx !== 1'b0 && t < 500) begin
            wait_cycles(1);
            t++;
        end
        check("rst_resp_started", ser_tx, 0);
        wait_cycles(20);
        #3 resetn = 1'b0;
        #1;
        check("rst_resp_ser_tx", ser_tx, 1);
        check("rst_resp_valid", cbus_valid, 0);
        wait_cycles(4);
        resetn = 1'b1;
        exp_rsp.delete();
        exp_txn.delete();
        rx_q.delete();
        wait_cycles(20);
        run_frame(1, 32'h5555AAAA, 32'h01234567, 4, 32'h0, "post_rst");

        slv_lat = 0;
        model_frame(0, 32'h70000000, 32'h0, 0, 32'h0);
        send_frame(0, 32'h70000000, 32'h0);
        t = 0;
        while (cbus_valid !== 1'b1 && t < 200) begin
            wait_cycles(1);
            t++;
        end
        check("exec_valid_seen", cbus_valid, 1);
        wait_cycles(5);
        #3 resetn = 1'b0;
        #1;
        check("rst_exec_valid", cbus_valid, 0);
        check("rst_exec_addr", cbus_addr, 0);
        check("rst_exec_wstrb", cbus_wstrb, 0);
        check("rst_exec_ser_tx", ser_tx, 1);
        wait_cycles(4);
        resetn = 1'b1;
        exp_rsp.delete();
        exp_txn.delete();
        rx_q.delete();
        wait_cycles(20);
        run_frame(1, 32'h00001234, 32'hFEEDC0DE, 2, 32'h0, "post_rst2");
        lit_rsp("post_rst2_rsp_lit", 0, 8'h4B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
